// File: rtl/fifo_uart_tx_if.sv
// Handshake bundle between the FIFO, the enable source and the UART transmitter.
// The transmitter takes the slave side; the FIFO/driver side takes the master side.
interface fifo_uart_tx_if;
  logic       tx_en;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_rd_en;
  logic       tx;
  logic       busy;
  logic       tx_done;

  modport master (
    output tx_en, fifo_empty, fifo_dout,
    input  fifo_rd_en, tx, busy, tx_done
  );

  modport slave (
    input  tx_en, fifo_empty, fifo_dout,
    output fifo_rd_en, tx, busy, tx_done
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a synchronous FIFO with one-cycle read latency.
// Frame: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic          clk,
  input  logic          rst,
  fifo_uart_tx_if.slave bus
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic ODD_BIT = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE, REQ, LOAD, START, DATA, PARITY, STOP
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d, baud_nxt;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          rd_q, rd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          tick;

  assign tick     = (baud_q == BAUD_MAX);
  assign baud_nxt = tick ? '0 : baud_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    tx_d    = tx_q;
    rd_d    = rd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (bus.tx_en && !bus.fifo_empty) begin
          rd_d    = 1'b1;
          busy_d  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        rd_d    = 1'b0;
        state_d = LOAD;
      end
      // Read data is valid now, one cycle after the strobe was sampled.
      LOAD: begin
        sh_d    = bus.fifo_dout;
        par_d   = (^bus.fifo_dout) ^ ODD_BIT;
        tx_d    = 1'b0;
        baud_d  = '0;
        bit_d   = '0;
        state_d = START;
      end
      START: begin
        baud_d = baud_nxt;
        if (tick) begin
          tx_d    = sh_q[0];
          sh_d    = {1'b0, sh_q[7:1]};
          state_d = DATA;
        end
      end
      DATA: begin
        baud_d = baud_nxt;
        if (tick) begin
          if (bit_q == 3'd7) begin
            bit_d = '0;
            if (PARITY_EN != 0) begin
              tx_d    = par_q;
              state_d = PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = STOP;
            end
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = sh_q[0];
            sh_d  = {1'b0, sh_q[7:1]};
          end
        end
      end
      PARITY: begin
        baud_d = baud_nxt;
        if (tick) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
      // bit_q is reused here to count stop bits.
      STOP: begin
        baud_d = baud_nxt;
        if (tick) begin
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.tx         = tx_q;
  assign bus.fifo_rd_en = rd_q;
  assign bus.busy       = busy_q;
  assign bus.tx_done    = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three parameter sets driven from a FIFO model,
// line levels compared cycle by cycle against frames built from each byte.
module tb_fifo_uart_tx;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int uf     = 0;

  int P_EN [3] = '{0, 1, 1};
  int P_ODD[3] = '{0, 0, 1};
  int SB   [3] = '{1, 1, 2};

  logic       en  [3] = '{default: 1'b0};
  logic [7:0] mem [3][16];
  logic [3:0] wp  [3] = '{default: 4'd0};
  logic [3:0] rp  [3] = '{default: 4'd0};
  logic [7:0] dout[3] = '{default: 8'd0};
  logic rd_w[3], tx_w[3], busy_w[3], done_w[3];

  fifo_uart_tx_if ifc0 ();
  fifo_uart_tx_if ifc1 ();
  fifo_uart_tx_if ifc2 ();

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    dut0 (.clk(clk), .rst(rst), .bus(ifc0));
  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    dut1 (.clk(clk), .rst(rst), .bus(ifc1));
  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2))
    dut2 (.clk(clk), .rst(rst), .bus(ifc2));

  assign ifc0.tx_en      = en[0];
  assign ifc0.fifo_empty = (wp[0] == rp[0]);
  assign ifc0.fifo_dout  = dout[0];
  assign rd_w[0]   = ifc0.fifo_rd_en;
  assign tx_w[0]   = ifc0.tx;
  assign busy_w[0] = ifc0.busy;
  assign done_w[0] = ifc0.tx_done;

  assign ifc1.tx_en      = en[1];
  assign ifc1.fifo_empty = (wp[1] == rp[1]);
  assign ifc1.fifo_dout  = dout[1];
  assign rd_w[1]   = ifc1.fifo_rd_en;
  assign tx_w[1]   = ifc1.tx;
  assign busy_w[1] = ifc1.busy;
  assign done_w[1] = ifc1.tx_done;

  assign ifc2.tx_en      = en[2];
  assign ifc2.fifo_empty = (wp[2] == rp[2]);
  assign ifc2.fifo_dout  = dout[2];
  assign rd_w[2]   = ifc2.fifo_rd_en;
  assign tx_w[2]   = ifc2.tx;
  assign busy_w[2] = ifc2.busy;
  assign done_w[2] = ifc2.tx_done;

  // Synchronous FIFO model: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rd_w[i] === 1'b1) begin
        if (wp[i] == rp[i]) uf <= uf + 1;
        else begin
          dout[i] <= mem[i][rp[i]];
          rp[i]   <= rp[i] + 4'd1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] b);
    mem[i][wp[i]] = b;
    wp[i] = wp[i] + 4'd1;
  endtask

  task automatic idle_chk(input int i, input int cyc, input string tag);
    for (int c = 0; c < cyc; c++) begin
      @(negedge clk);
      chk($sformatf("%s_rd%0d", tag, i), rd_w[i], 1'b0);
      chk($sformatf("%s_tx%0d", tag, i), tx_w[i], 1'b1);
      chk($sformatf("%s_busy%0d", tag, i), busy_w[i], 1'b0);
      chk($sformatf("%s_done%0d", tag, i), done_w[i], 1'b0);
    end
  endtask

  // Waits for the read strobe, then checks the whole frame cycle by cycle.
  task automatic frame(input int i, input logic [7:0] b, input int max_wait,
                       input int drop_k, output int waited);
    logic bits [12];
    int n;
    bits[0] = 1'b0;
    for (int j = 0; j < 8; j++) bits[1+j] = b[j];
    n = 9;
    if (P_EN[i] != 0) begin
      bits[9] = (^b) ^ (P_ODD[i] != 0);
      n = 10;
    end
    for (int s = 0; s < SB[i]; s++) bits[n+s] = 1'b1;
    n = n + SB[i];
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (rd_w[i] !== 1'b1 && waited < max_wait);
    chk($sformatf("rd_seen%0d", i), rd_w[i], 1'b1);
    if (rd_w[i] !== 1'b1) return;
    chk($sformatf("busy_acc%0d", i), busy_w[i], 1'b1);
    @(negedge clk);
    chk($sformatf("rd_pulse%0d", i), rd_w[i], 1'b0);
    chk($sformatf("tx_pre%0d", i), tx_w[i], 1'b1);
    for (int k = 0; k < n * CPB; k++) begin
      @(negedge clk);
      if (k == drop_k) en[i] = 1'b0;
      chk($sformatf("tx%0d_b%02h_k%0d", i, b, k), tx_w[i], bits[k / CPB]);
      chk($sformatf("busy%0d_k%0d", i, k), busy_w[i], 1'b1);
      chk($sformatf("done%0d_k%0d", i, k), done_w[i], 1'b0);
      chk($sformatf("rd%0d_k%0d", i, k), rd_w[i], 1'b0);
    end
    @(negedge clk);
    chk($sformatf("done_end%0d", i), done_w[i], 1'b1);
    chk($sformatf("busy_end%0d", i), busy_w[i], 1'b0);
    chk($sformatf("tx_end%0d", i), tx_w[i], 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    int cnt;
    logic [7:0] b, b2;
    logic [7:0] q[$];

    // Reset state
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("rst_tx%0d", i), tx_w[i], 1'b1);
        chk($sformatf("rst_busy%0d", i), busy_w[i], 1'b0);
        chk($sformatf("rst_rd%0d", i), rd_w[i], 1'b0);
        chk($sformatf("rst_done%0d", i), done_w[i], 1'b0);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) en[i] = 1'b1;
    for (int i = 0; i < 3; i++) idle_chk(i, 4, "empty");

    // Single frame, acceptance latency of one cycle to the strobe
    push(0, 8'hA5);
    frame(0, 8'hA5, 6, -1, w);
    chk("accept_lat", w, 1);
    idle_chk(0, 5, "post1");

    // Parity cases, then randomized bytes
    push(1, 8'hA5);
    frame(1, 8'hA5, 6, -1, w);
    push(1, 8'h07);
    frame(1, 8'h07, 6, -1, w);
    push(2, 8'h07);
    frame(2, 8'h07, 6, -1, w);
    for (int r = 0; r < 4; r++) begin
      b  = 8'($urandom);
      b2 = 8'($urandom);
      push(1, b);
      frame(1, b, 6, -1, w);
      push(2, b2);
      frame(2, b2, 6, -1, w);
    end

    // Back-to-back drain
    push(0, 8'h01);
    push(0, 8'h02);
    push(0, 8'h03);
    frame(0, 8'h01, 6, -1, w);
    frame(0, 8'h02, 6, -1, w);
    chk("gap2", w, 1);
    frame(0, 8'h03, 6, -1, w);
    chk("gap3", w, 1);
    idle_chk(0, 10, "drained");

    q = {};
    for (int r = 0; r < 4; r++) begin
      b = 8'($urandom);
      q.push_back(b);
      push(0, b);
    end
    cnt = 0;
    while (q.size() > 0) begin
      b = q.pop_front();
      frame(0, b, 6, -1, w);
      if (cnt > 0) chk("gap_rand", w, 1);
      cnt++;
    end
    chk("fifo_drained", rp[0], wp[0]);
    idle_chk(0, 5, "drained_r");

    // tx_en gating during data bits
    b  = 8'($urandom);
    b2 = 8'($urandom);
    push(0, b);
    push(0, b2);
    frame(0, b, 6, 3 * CPB, w);
    idle_chk(0, 10, "gated");
    en[0] = 1'b1;
    frame(0, b2, 6, -1, w);
    chk("en_restart", (w <= 3), 1'b1);

    // Reset during data bit 3
    b  = 8'($urandom);
    b2 = 8'($urandom);
    push(0, b);
    push(0, b2);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (rd_w[0] !== 1'b1 && cnt < 6);
    chk("mr_rd", rd_w[0], 1'b1);
    repeat (2 + 4 * CPB + 1) @(negedge clk);
    chk("mr_busy_pre", busy_w[0], 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("mr_tx", tx_w[0], 1'b1);
    chk("mr_busy", busy_w[0], 1'b0);
    chk("mr_rd0", rd_w[0], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    frame(0, b2, 6, -1, w);
    chk("mr_fifo", rp[0], wp[0]);
    idle_chk(0, 5, "final");

    chk("no_underflow", uf, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
